// File: rtl/crypto_issue_ctrl.sv
// EX-stage sequencer for the multi-cycle crypto unit: decodes crypto instructions,
// issues one op per instruction, stalls the core while busy and presents the result for one cycle.
module crypto_issue_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [6:0]      opcode,
  input  logic [4:0]      func5,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            crypto_start,
  output logic [3:0]      crypto_op,
  output logic [XLEN-1:0] crypto_rs1,
  output logic [XLEN-1:0] crypto_rs2,
  input  logic            crypto_done,
  input  logic [XLEN-1:0] crypto_result,
  output logic            stall,
  output logic            crypto_sel,
  output logic [XLEN-1:0] wb_result,
  output logic            timeout_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] wb_q;
  logic            terr_q;
  logic [4:0]      dec;
  logic            is_crypto;
  logic [3:0]      dec_op;
  logic            issue;

  // Returns {is_crypto, op}.
  function automatic logic [4:0] decode(input logic [6:0] opc, input logic [4:0] f5,
                                        input logic [2:0] f3);
    logic [4:0] r;
    r = 5'b0_0000;
    if (opc == 7'b0110011) begin
      unique case (f5)
        5'b10101: if (f3 == 3'b000) r = 5'h10;
        5'b10111: if (f3 == 3'b000) r = 5'h11;
        5'b10001: if (f3 == 3'b000) r = 5'h12;
        5'b10011: if (f3 == 3'b000) r = 5'h13;
        5'b00101: if (f3 == 3'b001) r = 5'h14; else if (f3 == 3'b011) r = 5'h15;
        5'b10100: if (f3 == 3'b010) r = 5'h16; else if (f3 == 3'b100) r = 5'h17;
        5'b00100: if (f3 == 3'b001) r = 5'h18; else if (f3 == 3'b101) r = 5'h19;
        default:  r = 5'b0_0000;
      endcase
    end else if (opc == 7'b0010011) begin
      if (f5 == 5'b01000) begin
        if (f3 == 3'b001) r = 5'h1A; else if (f3 == 3'b101) r = 5'h1B;
      end else if (f5 == 5'b10100) begin
        if (f3 == 3'b001) r = 5'h1C; else if (f3 == 3'b101) r = 5'h1D;
      end
    end
    return r;
  endfunction

  always_comb begin
    dec       = decode(opcode, func5, func3);
    is_crypto = dec[4];
    dec_op    = dec[3:0];
    // Reset gating keeps the start pulse quiet while the unit itself is being reset.
    issue     = ~reset & ex_valid & is_crypto & ~flush & (state == IDLE);
  end

  // Operands pass straight through in the issue cycle, then come from the latch.
  assign crypto_start = issue;
  assign crypto_op    = issue ? dec_op : 4'd0;
  assign crypto_rs1   = issue ? rs1_data : rs1_q;
  assign crypto_rs2   = issue ? rs2_data : rs2_q;
  assign stall        = issue | (state == BUSY) | (state == DRAIN);
  assign crypto_sel   = (state == DONE);
  assign wb_result    = wb_q;
  assign timeout_err  = terr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      wb_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            rs1_q <= rs1_data;
            rs2_q <= rs2_data;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (crypto_done) begin
            wb_q  <= crypto_result;
            state <= DONE;
          end else if (flush) begin
            state <= DRAIN;
          end else if (cnt == CNT_LAST) begin
            terr_q <= 1'b1;
            wb_q   <= '0;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          // The killed op is still in flight; wait it out so its done pulse is not misread.
          if (crypto_done) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            terr_q <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
